collide_result_reader: RTL
==========================

// Module: collide_result_reader
// PURPOSE
//  Consumer end of the dCollideSpheres result interface. Detects each rising edge of the collider's done,
//  snapshots the result bus (cx,cy,cz,normalx/y/z,depth,ret) into a 2-entry frame buffer, and drains each
//  frame as an 8-word stream over valid/ready toward the host/readback logic. Replaces bench-side probing.
// PARAMETERS
//  W          32     word width (IEEE-754 single for coords/normal/depth)
//  SKIP_MISS  0      1: drop frames whose ret==0 (no contact) silently, no seq/drop count change
//  SYNC       8'hC5  header sync byte
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  done       in   1   collider done (level; only 0->1 transition is an event)
//  cx,cy,cz   in   W   contact point
//  normalx/y/z in  W   contact normal
//  depth      in   W   penetration depth
//  ret        in   W   contact count/flag from collider
//  out_data   out  W   stream word
//  out_valid  out  1   out_data valid
//  out_last   out  1   high with final word of frame
//  out_ready  in   1   downstream accept
//  drop_cnt   out  8   saturating count of frames lost to full buffer
//  busy       out  1   buffer non-empty
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0, out_last=0, out_data=0, drop_cnt=0, busy=0, seq=0, buffer empty,
//    done_q=0, state IDLE. Partially sent frame is discarded; no residue after release.
//  - Event: done=1 && done_q=0 sampled at edge k. Inputs are captured at that same edge. done held high
//    generates one event only. A done high at reset release counts as an event at the first edge.
//  - Capture: if buffer count<2 (or count==2 and a frame's last word is accepted at edge k), write entry,
//    wr_ptr++. Otherwise drop_cnt++ (saturate at 255), frame lost. SKIP_MISS=1 && ret==0: ignore.
//  - Frame: word0 header {SYNC, seq[7:0], drop_cnt[7:0], 7'b0, contact}, contact=(ret!=0);
//    words1..7 = cx,cy,cz,normalx,normaly,normalz,depth. out_last on word7. seq increments
//    (mod 256, wraps 255->0) per frame captured, value stamped at capture.
//  - FSM: IDLE -> SEND when buffer non-empty; SEND: word index 0..7 advances only on out_valid&&out_ready;
//    on accepting word7: rd_ptr++, go IDLE if buffer becomes empty else stay SEND with index 0 (back-to-back,
//    no bubble). Latency: event at edge k into empty buffer -> out_valid=1 header after edge k+1.
//  - Handshake: out_data/out_last stable while out_valid && !out_ready; out_valid never deasserts
//    without acceptance; out_valid may not depend combinationally on out_ready.
//  - Simultaneous capture and final-word accept on full buffer: capture succeeds, no drop.
//  - busy = (count!=0). drop_cnt holds until reset.
// STRUCTURE
//  - Shared package/header: W, SYNC, FRAME_WORDS=8, word index encodings, FSM state encodings.
//  - One sub-module natural: collide_frame_buf (2-entry x 7-word+header-field storage, ptrs, count,
//    full/empty, simultaneous push/pop). Edge detect, FSM, mux in top.
// TESTING
//  1 Reset, sphere pair x=-0.4927/+0.4927 y=0 z=1.5 r=0.5, one done pulse, out_ready=1 -> 8 words:
//    header 0xC5000001, then model cx..depth bit-exact, out_last only on word7, header 1 cycle after capture.
//  2 done held high 50 cycles -> exactly one frame; seq next frame =1.
//  3 out_ready=0, three done events -> two frames buffered, drop_cnt=1; release ready -> seq 0,1 streamed
//    back-to-back (16 consecutive valid cycles), header of frame 2 shows drop_cnt=1.
//  4 Random out_ready stall (50%) -> out_data/out_last stable during stalls, no word lost/duplicated.
//  5 Full buffer + done edge on same edge as word7 accept -> frame captured, drop_cnt unchanged.
//  6 rst low mid-frame (word 3) -> out_valid=0 immediately, after release no output until new done;
//    SKIP_MISS=1 with ret=0 -> no frame, seq unchanged; 256 frames -> seq wraps to 0.

Source files
------------

// File: rtl/collide_result_reader_pkg.sv
// Shared constants, word-index and FSM encodings for the collide result reader.
package collide_result_reader_pkg;

  localparam int         W_DEF       = 32;
  localparam logic [7:0] SYNC_DEF    = 8'hC5;
  localparam int         FRAME_WORDS = 8;
  localparam int         DATA_WORDS  = FRAME_WORDS - 1;

  typedef logic [2:0] widx_t;
  localparam widx_t WI_HDR  = 3'd0;
  localparam widx_t WI_LAST = 3'(FRAME_WORDS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  function automatic logic [31:0] make_hdr(input logic [7:0] sync, input logic [7:0] seq,
                                           input logic [7:0] drop, input logic contact);
    return {sync, seq, drop, 7'b0, contact};
  endfunction

endpackage

// File: rtl/collide_frame_buf.sv
// Two-entry frame store: seven data words plus seq/contact per entry, with concurrent push/pop.
module collide_frame_buf
  import collide_result_reader_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_WORDS-1:0][W-1:0] wr_words,
  input  logic [7:0]                   wr_seq,
  input  logic                         wr_contact,
  output logic [DATA_WORDS-1:0][W-1:0] rd_words,
  output logic [7:0]                   rd_seq,
  output logic                         rd_contact,
  output logic [1:0]                   count,
  output logic                         empty,
  output logic                         full
);

  logic [1:0][DATA_WORDS-1:0][W-1:0] mem;
  logic [1:0][7:0]                   seq_m;
  logic [1:0]                        con_m;
  logic                              wr_ptr, rd_ptr;

  // When full, a push is only issued together with a pop, so wr_ptr==rd_ptr
  // overwrites the entry whose last word is leaving on this same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      seq_m  <= '0;
      con_m  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]   <= wr_words;
        seq_m[wr_ptr] <= wr_seq;
        con_m[wr_ptr] <= wr_contact;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  assign rd_words   = mem[rd_ptr];
  assign rd_seq     = seq_m[rd_ptr];
  assign rd_contact = con_m[rd_ptr];
  assign empty      = (count == 2'd0);
  assign full       = (count == 2'd2);

endmodule

// File: rtl/collide_result_reader.sv
// Captures collider results on each done rising edge and streams them as 8-word frames over valid/ready.
module collide_result_reader
  import collide_result_reader_pkg::*;
#(
  parameter int         W         = W_DEF,
  parameter bit         SKIP_MISS = 1'b0,
  parameter logic [7:0] SYNC      = SYNC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         done,
  input  logic [W-1:0] cx,
  input  logic [W-1:0] cy,
  input  logic [W-1:0] cz,
  input  logic [W-1:0] normalx,
  input  logic [W-1:0] normaly,
  input  logic [W-1:0] normalz,
  input  logic [W-1:0] depth,
  input  logic [W-1:0] ret,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic [7:0]   drop_cnt,
  output logic         busy
);

  logic                         done_q, ev, want, accept, pop, push, drop, drains, load_hdr;
  logic [7:0]                   seq, hdr_drop, rd_seq;
  logic                         rd_contact, empty, full;
  logic [1:0]                   count;
  logic [DATA_WORDS-1:0][W-1:0] cap_words, rd_words;
  state_t                       state, state_nx;
  widx_t                        idx, idx_nx;

  assign cap_words = {depth, normalz, normaly, normalx, cz, cy, cx};

  assign ev        = done & ~done_q;
  assign want      = ev & ~(SKIP_MISS & (ret == '0));
  assign out_valid = (state == S_SEND);
  assign accept    = out_valid & out_ready;
  assign pop       = accept & (idx == WI_LAST);
  assign push      = want & (~full | pop);
  assign drop      = want & full & ~pop;
  assign drains    = pop & (count == 2'd1) & ~push;
  assign busy      = ~empty;
  assign out_last  = out_valid & (idx == WI_LAST);

  collide_frame_buf #(.W(W)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .wr_words   (cap_words),
    .wr_seq     (seq),
    .wr_contact (ret != '0),
    .rd_words   (rd_words),
    .rd_seq     (rd_seq),
    .rd_contact (rd_contact),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    load_hdr = 1'b0;
    case (state)
      S_IDLE: if (!empty) begin
        state_nx = S_SEND;
        idx_nx   = WI_HDR;
        load_hdr = 1'b1;
      end
      S_SEND: if (accept) begin
        if (idx == WI_LAST) begin
          idx_nx = WI_HDR;
          if (drains) state_nx = S_IDLE;
          else        load_hdr = 1'b1;
        end else begin
          idx_nx = idx + 3'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Drop count is frozen into the header when it is first presented so the
  // word stays stable through a stall even if a later frame is lost meanwhile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q   <= 1'b0;
      state    <= S_IDLE;
      idx      <= WI_HDR;
      seq      <= 8'd0;
      drop_cnt <= 8'd0;
      hdr_drop <= 8'd0;
    end else begin
      done_q <= done;
      state  <= state_nx;
      idx    <= idx_nx;
      if (push) seq <= seq + 8'd1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (load_hdr) hdr_drop <= drop_cnt;
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      if (idx == WI_HDR) out_data = W'(make_hdr(SYNC, rd_seq, hdr_drop, rd_contact));
      else               out_data = rd_words[idx - 3'd1];
    end
  end

endmodule
